// File: rtl/fechadura_pkg.sv
// rtl/fechadura_pkg.sv - shared door-alarm types and timeout limits
package fechadura_pkg;

   typedef enum logic [1:0] {
      FECHADA    = 2'd0,
      CONTANDO   = 2'd1,
      ALARME     = 2'd2,
      SILENCIADO = 2'd3
   } estado_porta_t;

   localparam int TEMPO_MIN = 5;
   localparam int TEMPO_MAX = 60;

endpackage

// File: rtl/temporizador_porta.sv
// rtl/temporizador_porta.sv - one door channel: open-time counter and alarm FSM
module temporizador_porta
   import fechadura_pkg::*;
#(
   parameter int W_CNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             aberta,
   input  logic [W_CNT-1:0] limite,
   input  logic             silenciar,
   output logic             alarme,
   output logic             alarme_prox
);

   estado_porta_t    r_estado;
   estado_porta_t    w_estado_prox;
   logic [W_CNT-1:0] r_cnt;
   logic [W_CNT-1:0] w_cnt_prox;
   logic [W_CNT-1:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == {W_CNT{1'b1}}) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_estado_prox = r_estado;
      w_cnt_prox    = r_cnt;
      if (!aberta) begin
         w_estado_prox = FECHADA;
         w_cnt_prox    = '0;
      end else begin
         case (r_estado)
            FECHADA: begin
               w_estado_prox = CONTANDO;
               w_cnt_prox    = {{(W_CNT-1){1'b0}}, 1'b1};
            end
            CONTANDO: begin
               w_cnt_prox = w_cnt_inc;
               // >= so a shortened timeout fires on the next edge for late counts
               if (w_cnt_inc >= limite)
                  w_estado_prox = silenciar ? SILENCIADO : ALARME;
            end
            ALARME: begin
               w_cnt_prox = w_cnt_inc;
               if (silenciar)
                  w_estado_prox = SILENCIADO;
            end
            default: begin
               w_cnt_prox = w_cnt_inc;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= FECHADA;
         r_cnt    <= '0;
      end else begin
         r_estado <= w_estado_prox;
         r_cnt    <= w_cnt_prox;
      end
   end

   assign alarme      = (r_estado == ALARME);
   assign alarme_prox = (w_estado_prox == ALARME) && !rst;

endmodule

// File: rtl/alarme_porta.sv
// rtl/alarme_porta.sv - multi-door open-timeout alarm with channel encoder and buzzer
module alarme_porta
   import fechadura_pkg::*;
#(
   parameter int N_PORTAS     = 2,
   parameter int CICLOS_SEG   = 1000,
   parameter int TEMPO_PADRAO = 5,
   parameter int MODO_BIP     = 0,
   parameter int PERIODO_BIP  = 250
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTAS-1:0]         sensor_contato,
   input  logic [N_PORTAS-1:0]         tranca,
   input  logic [5:0]                  tempo_cfg,
   input  logic                        tempo_cfg_valid,
   input  logic                        silenciar,
   output logic [N_PORTAS-1:0]         alarme_ativo,
   output logic [$clog2(N_PORTAS):0]   canal_alarme,
   output logic                        bip
);

   localparam int W_CNT   = $clog2(60*CICLOS_SEG+1);
   localparam int W_CANAL = $clog2(N_PORTAS) + 1;
   localparam int W_FASE  = $clog2(PERIODO_BIP+1);

   logic [5:0]          r_tempo;
   logic [W_CNT-1:0]    w_limite;
   logic [N_PORTAS-1:0] w_alarme;
   logic [N_PORTAS-1:0] w_alarme_prox;
   logic [W_CANAL-1:0]  w_canal_prox;
   logic [W_CANAL-1:0]  r_canal;
   logic [W_FASE-1:0]   r_fase;
   logic                r_bip;
   logic                w_alguma_prox;

   always_ff @(posedge clk) begin
      if (rst)
         r_tempo <= 6'(TEMPO_PADRAO);
      else if (tempo_cfg_valid && (tempo_cfg >= 6'(TEMPO_MIN)) && (tempo_cfg <= 6'(TEMPO_MAX)))
         r_tempo <= tempo_cfg;
   end

   assign w_limite = W_CNT'(32'(r_tempo) * CICLOS_SEG);

   genvar g;
   generate
      for (g = 0; g < N_PORTAS; g++) begin : g_canal
         temporizador_porta #(
            .W_CNT (W_CNT)
         ) u_temporizador (
            .clk         (clk),
            .rst         (rst),
            .aberta      (sensor_contato[g] && !tranca[g]),
            .limite      (w_limite),
            .silenciar   (silenciar),
            .alarme      (w_alarme[g]),
            .alarme_prox (w_alarme_prox[g])
         );
      end
   endgenerate

   // Encoder and buzzer register the next alarm vector so they track alarme_ativo edge for edge
   always_comb begin
      w_canal_prox = {W_CANAL{1'b1}};
      for (int i = N_PORTAS-1; i >= 0; i--) begin
         if (w_alarme_prox[i])
            w_canal_prox = W_CANAL'(i);
      end
   end

   assign w_alguma_prox = |w_alarme_prox;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_canal <= {W_CANAL{1'b1}};
         r_fase  <= '0;
         r_bip   <= 1'b0;
      end else begin
         r_canal <= w_canal_prox;
         if (!w_alguma_prox) begin
            r_fase <= '0;
            r_bip  <= 1'b0;
         end else if (MODO_BIP == 0) begin
            r_bip <= 1'b1;
         end else if (!(|w_alarme)) begin
            r_fase <= '0;
            r_bip  <= 1'b1;
         end else if (r_fase == W_FASE'(PERIODO_BIP-1)) begin
            r_fase <= '0;
            r_bip  <= !r_bip;
         end else begin
            r_fase <= r_fase + 1'b1;
         end
      end
   end

   assign alarme_ativo = w_alarme;
   assign canal_alarme = r_canal;
   assign bip          = r_bip;

endmodule

// File: tb/tb_alarme_porta.sv
// tb/tb_alarme_porta.sv - directed self-checking bench for alarme_porta
module tb_alarme_porta;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sensor_contato;
   logic [1:0] tranca;
   logic [5:0] tempo_cfg;
   logic       tempo_cfg_valid;
   logic       silenciar;
   logic [1:0] alarme_ativo;
   logic [1:0] canal_alarme;
   logic       bip;

   logic [0:0] sensor2;
   logic [0:0] tranca2;
   logic [5:0] tempo_cfg2;
   logic       tempo_cfg_valid2;
   logic       silenciar2;
   logic [0:0] alarme2;
   logic [0:0] canal2;
   logic       bip2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alarme_porta #(
      .N_PORTAS(2), .CICLOS_SEG(1000), .TEMPO_PADRAO(5), .MODO_BIP(0), .PERIODO_BIP(250)
   ) dut (
      .clk(clk), .rst(rst), .sensor_contato(sensor_contato), .tranca(tranca),
      .tempo_cfg(tempo_cfg), .tempo_cfg_valid(tempo_cfg_valid), .silenciar(silenciar),
      .alarme_ativo(alarme_ativo), .canal_alarme(canal_alarme), .bip(bip)
   );

   alarme_porta #(
      .N_PORTAS(1), .CICLOS_SEG(200), .TEMPO_PADRAO(5), .MODO_BIP(1), .PERIODO_BIP(250)
   ) dut_bip (
      .clk(clk), .rst(rst), .sensor_contato(sensor2), .tranca(tranca2),
      .tempo_cfg(tempo_cfg2), .tempo_cfg_valid(tempo_cfg_valid2), .silenciar(silenciar2),
      .alarme_ativo(alarme2), .canal_alarme(canal2), .bip(bip2)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe_cfg(input logic [5:0] v);
      tempo_cfg = v;
      tempo_cfg_valid = 1'b1;
      step(1);
      tempo_cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(2);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL reset_alarme got %b want 00", alarme_ativo); end
      checks++; if (canal_alarme !== 2'b11) begin errors++; $display("FAIL reset_canal got %b want 11", canal_alarme); end
      checks++; if (bip !== 1'b0) begin errors++; $display("FAIL reset_bip got %b want 0", bip); end
      checks++; if (bip2 !== 1'b0 || canal2 !== 1'b1) begin errors++; $display("FAIL reset_dut2 got bip %b canal %b want 0 1", bip2, canal2); end
      rst = 1'b0;
   endtask

   task automatic test_alarm_basic;
      sensor_contato = 2'b01;
      step(4999);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL basic_4999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b01) begin errors++; $display("FAIL basic_5000 got %b want 01", alarme_ativo); end
      checks++; if (canal_alarme !== 2'b00) begin errors++; $display("FAIL basic_canal got %b want 00", canal_alarme); end
      checks++; if (bip !== 1'b1) begin errors++; $display("FAIL basic_bip got %b want 1", bip); end
      sensor_contato = 2'b00;
      step(1);
      checks++; if (alarme_ativo !== 2'b00 || canal_alarme !== 2'b11 || bip !== 1'b0) begin
         errors++; $display("FAIL basic_close got %b/%b/%b want 00/11/0", alarme_ativo, canal_alarme, bip);
      end
   endtask

   task automatic test_short_open;
      logic bad;
      bad = 1'b0;
      sensor_contato = 2'b01;
      for (int k = 0; k < 4999; k++) begin
         step(1);
         if (bip !== 1'b0) bad = 1'b1;
      end
      sensor_contato = 2'b00;
      for (int k = 0; k < 5; k++) begin
         step(1);
         if (bip !== 1'b0 || alarme_ativo !== 2'b00) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL short_open bip_seen got 1 want 0"); end
   endtask

   task automatic test_cfg_ignored;
      strobe_cfg(6'd3);
      sensor_contato = 2'b01;
      step(4999);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL cfg3_4999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b01) begin errors++; $display("FAIL cfg3_5000 got %b want 01", alarme_ativo); end
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_cfg_midcount;
      strobe_cfg(6'd20);
      sensor_contato = 2'b10;
      step(7000);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL cfg_mid_7000 got %b want 00", alarme_ativo); end
      strobe_cfg(6'd10);
      step(2998);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL cfg_mid_9999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b10 || canal_alarme !== 2'b01) begin
         errors++; $display("FAIL cfg_mid_10000 got %b/%b want 10/01", alarme_ativo, canal_alarme);
      end
      sensor_contato = 2'b00;
      step(1);
      sensor_contato = 2'b01;
      step(6000);
      strobe_cfg(6'd5);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL cfg_shrink_strobe got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b01) begin errors++; $display("FAIL cfg_shrink_next got %b want 01", alarme_ativo); end
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_silence;
      sensor_contato = 2'b11;
      step(5000);
      checks++; if (alarme_ativo !== 2'b11 || canal_alarme !== 2'b00 || bip !== 1'b1) begin
         errors++; $display("FAIL sil_both got %b/%b/%b want 11/00/1", alarme_ativo, canal_alarme, bip);
      end
      silenciar = 1'b1;
      step(1);
      silenciar = 1'b0;
      checks++; if (alarme_ativo !== 2'b00 || canal_alarme !== 2'b11 || bip !== 1'b0) begin
         errors++; $display("FAIL sil_mute got %b/%b/%b want 00/11/0", alarme_ativo, canal_alarme, bip);
      end
      step(10);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL sil_hold got %b want 00", alarme_ativo); end
      sensor_contato = 2'b01;
      step(1);
      sensor_contato = 2'b11;
      step(4999);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL sil_reopen_4999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b10 || canal_alarme !== 2'b01 || bip !== 1'b1) begin
         errors++; $display("FAIL sil_reopen_5000 got %b/%b/%b want 10/01/1", alarme_ativo, canal_alarme, bip);
      end
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_silence_same_edge;
      sensor_contato = 2'b01;
      step(4999);
      silenciar = 1'b1;
      step(1);
      silenciar = 1'b0;
      checks++; if (alarme_ativo !== 2'b00 || bip !== 1'b0) begin
         errors++; $display("FAIL sil_same_edge got %b/%b want 00/0", alarme_ativo, bip);
      end
      step(5);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL sil_same_hold got %b want 00", alarme_ativo); end
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_lock;
      sensor_contato = 2'b01;
      step(4999);
      tranca = 2'b01;
      step(1);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL lock_edge got %b want 00", alarme_ativo); end
      tranca = 2'b00;
      step(4999);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL lock_restart_4999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b01) begin errors++; $display("FAIL lock_restart_5000 got %b want 01", alarme_ativo); end
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_reset_midcount;
      strobe_cfg(6'd20);
      sensor_contato = 2'b01;
      step(4000);
      rst = 1'b1;
      step(1);
      checks++; if (alarme_ativo !== 2'b00 || canal_alarme !== 2'b11 || bip !== 1'b0) begin
         errors++; $display("FAIL rst_mid got %b/%b/%b want 00/11/0", alarme_ativo, canal_alarme, bip);
      end
      rst = 1'b0;
      step(4999);
      checks++; if (alarme_ativo !== 2'b00) begin errors++; $display("FAIL rst_mid_4999 got %b want 00", alarme_ativo); end
      step(1);
      checks++; if (alarme_ativo !== 2'b01) begin errors++; $display("FAIL rst_mid_5000 got %b want 01", alarme_ativo); end
      rst = 1'b1;
      step(1);
      checks++; if (alarme_ativo !== 2'b00 || canal_alarme !== 2'b11 || bip !== 1'b0) begin
         errors++; $display("FAIL rst_alarm got %b/%b/%b want 00/11/0", alarme_ativo, canal_alarme, bip);
      end
      rst = 1'b0;
      sensor_contato = 2'b00;
      step(1);
   endtask

   task automatic test_bip_intermittent;
      int   bad;
      logic exp_bip;
      bad = 0;
      sensor2 = 1'b1;
      step(999);
      checks++; if (bip2 !== 1'b0) begin errors++; $display("FAIL bip2_pre got %b want 0", bip2); end
      step(1);
      for (int k = 0; k <= 1000; k++) begin
         exp_bip = ((k / 250) % 2) == 0;
         if (bip2 !== exp_bip) begin
            if (bad == 0) $display("FAIL bip2_pattern at k=%0d got %b want %b", k, bip2, exp_bip);
            bad++;
         end
         if (k < 1000) step(1);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bip2_pattern_total got %0d bad cycles want 0", bad); end
      sensor2 = 1'b0;
      step(1);
      checks++; if (bip2 !== 1'b0 || alarme2 !== 1'b0) begin
         errors++; $display("FAIL bip2_close got %b/%b want 0/0", bip2, alarme2);
      end
   endtask

   initial begin
      rst = 1'b1;
      sensor_contato = 2'b00;
      tranca = 2'b00;
      tempo_cfg = 6'd0;
      tempo_cfg_valid = 1'b0;
      silenciar = 1'b0;
      sensor2 = 1'b0;
      tranca2 = 1'b0;
      tempo_cfg2 = 6'd0;
      tempo_cfg_valid2 = 1'b0;
      silenciar2 = 1'b0;
      test_reset;
      test_alarm_basic;
      test_short_open;
      test_cfg_ignored;
      test_cfg_midcount;
      test_silence;
      test_silence_same_edge;
      test_lock;
      test_reset_midcount;
      test_bip_intermittent;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarme_porta.md
ALARME_PORTA -- requirements
Module: alarme_porta

Interface
- REQ-001 The block SHALL have parameter N_PORTAS, default 2, number of independently monitored doors (1..8).
- REQ-002 The block SHALL have parameter CICLOS_SEG, default 1000, clock cycles per second.
- REQ-003 The block SHALL have parameter TEMPO_PADRAO, default 5, open-door timeout in seconds after reset.
- REQ-004 The block SHALL have parameter MODO_BIP, default 0, where 0 means continuous bip and 1 means intermittent bip.
- REQ-005 The block SHALL have parameter PERIODO_BIP, default 250, half-period in cycles of the intermittent bip.
- REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
- REQ-007 Ports SHALL be:
  - clk  in  1  system clock
  - rst  in  1  synchronous active-high reset
  - sensor_contato  in  N_PORTAS  1 = door i open
  - tranca  in  N_PORTAS  1 = door i locked
  - tempo_cfg  in  6  new timeout in seconds
  - tempo_cfg_valid  in  1  one-cycle strobe for tempo_cfg
  - silenciar  in  1  one-cycle mute request
  - alarme_ativo  out  N_PORTAS  door i has exceeded its timeout and is not muted
  - canal_alarme  out  $clog2(N_PORTAS)+1  lowest active alarm index; all-ones when none is active
  - bip  out  1  buzzer drive

Function
- REQ-008 Each channel SHALL run its own FSM with states FECHADA, CONTANDO, ALARME and SILENCIADO.
- REQ-009 FECHADA -> CONTANDO SHALL occur on any edge where sensor_contato[i]=1 and tranca[i]=0; the channel counter loads 1 on that edge.
- REQ-010 In CONTANDO the counter SHALL increment by 1 per edge while the open condition holds.
- REQ-011 On the edge where the counter equals T = tempo_ativo*CICLOS_SEG, the channel SHALL enter ALARME; alarme_ativo[i] is registered high from that edge.
- REQ-012 Open for exactly T cycles SHALL give an alarm; T-1 open cycles followed by closure SHALL give no alarm.
- REQ-013 From any non-FECHADA state, the channel SHALL return to FECHADA and clear its counter on the first edge where sensor_contato[i]=0 or tranca[i]=1. alarme_ativo[i] falls on that same edge.
- REQ-014 silenciar=1 SHALL move every channel in ALARME to SILENCIADO, which clears alarme_ativo. Channels in CONTANDO are unaffected.
- REQ-015 SILENCIADO SHALL persist until the door closes; a later opening starts a new count.
- REQ-016 tempo_ativo SHALL load tempo_cfg when tempo_cfg_valid=1 and the value is in 5..60; out-of-range values are ignored.
- REQ-017 A new tempo_ativo SHALL apply to every comparison from the next edge, including counts already in progress.
- REQ-018 If a running counter is already >= the new T, the channel SHALL enter ALARME on the next edge.
- REQ-019 The counter width SHALL be $clog2(60*CICLOS_SEG+1). The counter saturates and never wraps.
- REQ-020 canal_alarme SHALL be a registered priority encode of alarme_ativo, lowest index first.
- REQ-021 With MODO_BIP=0, bip SHALL equal |alarme_ativo.
- REQ-022 With MODO_BIP=1, bip SHALL start high on the first cycle any alarm is active and toggle every PERIODO_BIP cycles.
- REQ-023 The phase counter SHALL reset to 0 and bip go low on the edge where no alarm remains.
- REQ-024 Simultaneous alarm entry by several channels SHALL not restart the bip phase.
- REQ-025 silenciar on the same edge as alarm entry SHALL take priority: the channel goes directly to SILENCIADO.

Reset
- REQ-026 On rst=1 at an edge, all channels SHALL enter FECHADA, all counters clear to 0, tempo_ativo becomes TEMPO_PADRAO, and the bip phase counter clears to 0.
- REQ-027 On that same reset edge, outputs SHALL become alarme_ativo=0, canal_alarme=all-ones and bip=0.
- REQ-028 Reset asserted mid-count or mid-alarm SHALL discard all progress; counting restarts from 1 on the first open edge after rst falls.

Structure
- REQ-029 The shared package fechadura_pkg SHALL hold the estado_porta_t enum and the constants TEMPO_MIN=5 and TEMPO_MAX=60.
- REQ-030 One sub-module, temporizador_porta, SHALL implement a single channel: FSM plus counter, with inputs for the open condition, T and silenciar, and output alarme.
- REQ-031 The top SHALL instantiate temporizador_porta N_PORTAS times through generate, and SHALL hold the tempo_ativo register, the encoder and the bip generator.

Verification (CICLOS_SEG=1000, TEMPO_PADRAO=5, N_PORTAS=2)
- REQ-032 Door 0 unlocked and open for 5000 edges -> alarme_ativo=01 and canal_alarme=0 after edge 5000, and bip=1.
- REQ-033 Door 0 open 4999 edges, then closed -> bip stays 0 throughout.
- REQ-034 tempo_cfg=3 strobed -> ignored, 5000-cycle timeout retained. tempo_cfg=10 strobed while door 1 is at count 7000 -> alarm at count 10000.
- REQ-035 Both doors alarming, silenciar pulse -> alarme_ativo=00 and bip=0. Door 1 closes and reopens -> new alarm after 5000 edges.
- REQ-036 MODO_BIP=1, PERIODO_BIP=250, alarm held for 1000 cycles -> bip pattern 250 high, 250 low, repeated twice.
- REQ-037 rst pulsed at count 4000, door held open afterwards -> alarm after 5000 edges counted from the release of rst.
